// File: rtl/ca_rule_infer_pkg.sv
// ca_pkg: shared CA types, rule width and wrap-aware neighbourhood helper
package ca_pkg;
  typedef enum logic [1:0] {EMPTY, READY, SCAN} state_t;
  localparam int RULE_W = 8;
  localparam int MAX_GRID = 64;
  localparam int POS_W = 6;
  function automatic logic [2:0] neigh_idx(input logic [MAX_GRID-1:0] grid, input logic [POS_W-1:0] last, input logic [POS_W-1:0] i);
    logic [POS_W-1:0] hi, lo;
    hi = (i == last) ? '0 : i + 1'b1;
    lo = (i == '0) ? last : i - 1'b1;
    return {grid[hi], grid[i], grid[lo]};
  endfunction
endpackage

// File: rtl/ca_rule_infer_if.sv
// ca_rule_infer_if: generation stream in, learned rule status out
interface ca_rule_infer_if #(parameter int GRID_SIZE = 5);
  logic                 clear;
  logic                 gen_valid;
  logic                 gen_ready;
  logic [GRID_SIZE-1:0] gen_data;
  logic [7:0]           rule;
  logic [7:0]           known;
  logic                 conflict;
  logic                 complete;
  logic                 busy;
  modport master (output clear, gen_valid, gen_data, input gen_ready, rule, known, conflict, complete, busy);
  modport slave (input clear, gen_valid, gen_data, output gen_ready, rule, known, conflict, complete, busy);
endinterface

// File: rtl/ca_rule_infer_table.sv
// ca_rule_table: learned rule entries, their known flags and sticky conflict
module ca_rule_table
  import ca_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [2:0]        idx,
  input  logic              val,
  output logic [RULE_W-1:0] rule,
  output logic [RULE_W-1:0] known,
  output logic              conflict
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule <= '0;
      known <= '0;
      conflict <= 1'b0;
    end else if (clr) begin
      rule <= '0;
      known <= '0;
      conflict <= 1'b0;
    end else if (we) begin
      if (!known[idx]) begin
        rule[idx] <= val;
        known[idx] <= 1'b1;
      end else if (rule[idx] != val) begin
        conflict <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ca_rule_infer.sv
// ca_rule_infer: reconstructs a radius-1 CA rule from successive generations
module ca_rule_infer
  import ca_pkg::*;
#(
  parameter int GRID_SIZE = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ca_rule_infer_if.slave bus
);
  localparam int CW = $clog2(GRID_SIZE);
  state_t state, next;
  logic [GRID_SIZE-1:0] prev, cur;
  logic [CW-1:0] cnt;
  logic xfer, last;
  logic [2:0] idx;
  assign xfer = bus.gen_valid && bus.gen_ready;
  assign last = cnt == CW'(GRID_SIZE - 1);
  assign idx = neigh_idx(MAX_GRID'(prev), POS_W'(GRID_SIZE - 1), POS_W'(cnt));
  assign bus.complete = &bus.known;
  always_comb begin
    next = state;
    bus.gen_ready = state != SCAN;
    bus.busy = state == SCAN;
    next = (state == EMPTY && xfer) ? READY :
           (state == READY && xfer) ? SCAN :
           (state == SCAN && last) ? READY : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      prev <= '0;
      cur <= '0;
      cnt <= '0;
    end else if (bus.clear) begin
      state <= EMPTY;
      cnt <= '0;
    end else begin
      state <= next;
      if (state == EMPTY && xfer) prev <= bus.gen_data;
      if (state == READY && xfer) begin
        cur <= bus.gen_data;
        cnt <= '0;
      end
      if (state == SCAN) begin
        if (last) prev <= cur;
        else cnt <= cnt + 1'b1;
      end
    end
  end
  ca_rule_table u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.clear),
    .we      (state == SCAN),
    .idx     (idx),
    .val     (cur[cnt]),
    .rule    (bus.rule),
    .known   (bus.known),
    .conflict(bus.conflict)
  );
endmodule
